// File: rtl/fas_pkg.sv
// Shared constants for the FFT-power collection and analysis stages.
package fas_pkg;

    localparam int unsigned FAS_DATA_WIDTH = 32;
    localparam int unsigned FAS_N_POINTS   = 16;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned ST_W           = 2;

    // Collector FSM encoding; ST_DRAIN is only reachable with POWER_PIPE_EN.
    localparam logic [ST_W-1:0] ST_COLLECT = ST_W'(0);
    localparam logic [ST_W-1:0] ST_START   = ST_W'(1);
    localparam logic [ST_W-1:0] ST_WAIT    = ST_W'(2);
    localparam logic [ST_W-1:0] ST_DRAIN   = ST_W'(3);

endpackage

// File: rtl/power_collect_power_calc.sv
// Combinational power of one complex sample: re*re + im*im, unsigned.
module power_calc #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/2-1:0] re,
    input  logic [DATA_WIDTH/2-1:0] im,
    output logic [DATA_WIDTH-1:0]   power
);

    localparam int unsigned HALF_W = DATA_WIDTH / 2;

    logic signed [DATA_WIDTH-1:0] re_x;
    logic signed [DATA_WIDTH-1:0] im_x;
    logic signed [DATA_WIDTH-1:0] re_sq;
    logic signed [DATA_WIDTH-1:0] im_sq;

    // Sign-extend, square; the sum peaks at 2^(DATA_WIDTH-1) and is read unsigned.
    always_comb begin
        re_x  = {{HALF_W{re[HALF_W-1]}}, re};
        im_x  = {{HALF_W{im[HALF_W-1]}}, im};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        power = DATA_WIDTH'(re_sq) + DATA_WIDTH'(im_sq);
    end

endmodule

// File: rtl/power_collect.sv
// Collects one frame of FFT bins (any order) as power words and hands the
// frame to the analysis stage. Optional macro POWER_PIPE_EN registers the
// power path and adds a DRAIN state before START.
module power_collect
    import fas_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FAS_DATA_WIDTH,
    parameter int unsigned N_POINTS   = FAS_N_POINTS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fft_valid,
    output logic                           fft_ready,
    input  logic [IDX_W-1:0]               fft_idx,
    input  logic [DATA_WIDTH/2-1:0]        fft_re,
    input  logic [DATA_WIDTH/2-1:0]        fft_im,
    output logic [DATA_WIDTH*N_POINTS-1:0] fft_res_out,
    output logic                           analysis_start,
    input  logic                           analysis_done,
    output logic                           dup_err
);

    logic [ST_W-1:0]       state_q, state_d;
    logic [N_POINTS-1:0]   mask_q, mask_d;
    logic [N_POINTS-1:0]   idx_onehot;
    logic                  ready_d, start_d, dup_d;
    logic                  accept;
    logic [DATA_WIDTH-1:0] power;
    logic [DATA_WIDTH-1:0] buf_q [N_POINTS];
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    assign accept     = fft_valid && fft_ready;
    assign idx_onehot = N_POINTS'(1) << fft_idx;

    power_calc #(.DATA_WIDTH(DATA_WIDTH)) u_power_calc (
        .re    (fft_re),
        .im    (fft_im),
        .power (power)
    );

    // Next state, acceptance mask, duplicate flag and next-cycle outputs.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dup_d   = dup_err;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if ((mask_q & idx_onehot) != '0) dup_d = 1'b1;
                    mask_d = mask_q | idx_onehot;
                    if (&mask_d) begin
`ifdef POWER_PIPE_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_START;
`endif
                    end
                end
            end
            ST_DRAIN: state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (analysis_done) begin
                    state_d = ST_COLLECT;
                    mask_d  = '0;
                    dup_d   = 1'b0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        ready_d = (state_d == ST_COLLECT);
        start_d = (state_d == ST_START);
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_COLLECT;
            mask_q         <= '0;
            fft_ready      <= 1'b1;
            analysis_start <= 1'b0;
            dup_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            fft_ready      <= ready_d;
            analysis_start <= start_d;
            dup_err        <= dup_d;
        end
    end

`ifdef POWER_PIPE_EN
    logic                  pipe_vld_q;
    logic [IDX_W-1:0]      pipe_idx_q;
    logic [DATA_WIDTH-1:0] pipe_pow_q;

    // One register stage between the multiplier and the buffer write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= 1'b0;
            pipe_idx_q <= '0;
            pipe_pow_q <= '0;
        end else begin
            pipe_vld_q <= accept;
            pipe_idx_q <= fft_idx;
            pipe_pow_q <= power;
        end
    end

    assign wr_en   = pipe_vld_q;
    assign wr_idx  = pipe_idx_q;
    assign wr_data = pipe_pow_q;
`else
    assign wr_en   = accept;
    assign wr_idx  = fft_idx;
    assign wr_data = power;
`endif

    // Frame buffer; a repeated index simply overwrites its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_POINTS); i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            buf_q[wr_idx] <= wr_data;
        end
    end

    // Output bus is a direct view of the buffer.
    for (genvar g = 0; g < int'(N_POINTS); g++) begin : g_out
        assign fft_res_out[g*DATA_WIDTH +: DATA_WIDTH] = buf_q[g];
    end

endmodule
